// File: rtl/wave_scheduler.sv
// wave_scheduler: per-SIMD wavefront scheduler that owns the PC context block's
// update/dispatch/address inputs. Allocates slots to new waves, picks ready waves
// round-robin for fetch, and retires completions by advancing or freeing slots.
module wave_scheduler #(
  parameter  int NUM_WAVES = 5,
  localparam int CW        = $clog2(NUM_WAVES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dispatch_valid,
  output logic                 dispatch_ready,
  output logic [CW-1:0]        dispatch_slot,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [CW-1:0]        issue_context,
  input  logic                 complete_valid,
  input  logic [CW-1:0]        complete_context,
  input  logic                 complete_exit,
  output logic                 update_pc,
  output logic                 dispatch_new_wave,
  output logic [CW-1:0]        active_context,
  output logic [NUM_WAVES-1:0] slot_free_mask,
  output logic                 idle
);

  typedef enum logic [1:0] {
    SLOT_FREE  = 2'd0,
    SLOT_READY = 2'd1,
    SLOT_BUSY  = 2'd2
  } slot_status_t;

  typedef enum logic {
    ST_SEL = 1'b0,
    ST_ISS = 1'b1
  } state_t;

  slot_status_t  slot_status      [NUM_WAVES];
  slot_status_t  slot_status_next [NUM_WAVES];
  state_t        state;
  state_t        state_next;
  logic [CW-1:0] last;
  logic [CW-1:0] last_next;
  logic [CW-1:0] cand;
  logic [CW-1:0] cand_next;

  logic          free_found;
  logic [CW-1:0] free_idx;
  logic          rr_found;
  logic [CW-1:0] rr_idx;
  logic [CW-1:0] rr_probe;
  int            rr_pos;
  logic          complete_hits_busy;
  logic          disp_ok;
  logic          dispatch_fire;
  logic          sel_fire;
  logic          issue_fire;

  // Lowest-index FREE slot is where the next dispatched wave lands.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_WAVES - 1; i >= 0; i--) begin
      if (slot_status[i] == SLOT_FREE) begin
        free_found = 1'b1;
        free_idx   = CW'(i);
      end
    end
  end

  // Round-robin search: first READY slot after the last issued one, wrapping.
  // Scanning from the far end down lets the nearest hit overwrite earlier ones.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_pos   = 0;
    rr_probe = '0;
    for (int k = NUM_WAVES; k >= 1; k--) begin
      rr_pos = int'(last) + k;
      if (rr_pos >= NUM_WAVES) begin
        rr_pos = rr_pos - NUM_WAVES;
      end
      rr_probe = CW'(rr_pos);
      if (slot_status[rr_probe] == SLOT_READY) begin
        rr_found = 1'b1;
        rr_idx   = rr_probe;
      end
    end
  end

  // A completion only changes status when it names a slot that is actually BUSY.
  always_comb begin
    complete_hits_busy = 1'b0;
    for (int i = 0; i < NUM_WAVES; i++) begin
      if (complete_context == CW'(i) && slot_status[i] == SLOT_BUSY) begin
        complete_hits_busy = 1'b1;
      end
    end
  end

  // PC-port arbitration: completion beats dispatch, dispatch beats selection.
  assign disp_ok       = free_found & ~complete_valid & (state == ST_SEL);
  assign dispatch_fire = dispatch_valid & disp_ok;
  assign sel_fire      = (state == ST_SEL) & ~complete_valid & ~dispatch_fire & rr_found;
  assign issue_fire    = (state == ST_ISS) & issue_ready;

  // Slot status transitions; dispatch, issue and completion each touch a
  // different status class so they never collide on one slot.
  always_comb begin
    for (int i = 0; i < NUM_WAVES; i++) begin
      slot_status_next[i] = slot_status[i];
      if (complete_valid && complete_context == CW'(i) && slot_status[i] == SLOT_BUSY) begin
        slot_status_next[i] = complete_exit ? SLOT_FREE : SLOT_READY;
      end
      if (dispatch_fire && free_idx == CW'(i)) begin
        slot_status_next[i] = SLOT_READY;
      end
      if (issue_fire && cand == CW'(i)) begin
        slot_status_next[i] = SLOT_BUSY;
      end
    end
  end

  // State register: FSM, round-robin pointer, latched candidate and slot status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_SEL;
      last  <= CW'(NUM_WAVES - 1);
      cand  <= '0;
      for (int i = 0; i < NUM_WAVES; i++) begin
        slot_status[i] <= SLOT_FREE;
      end
    end else begin
      state <= state_next;
      last  <= last_next;
      cand  <= cand_next;
      for (int i = 0; i < NUM_WAVES; i++) begin
        slot_status[i] <= slot_status_next[i];
      end
    end
  end

  // Next-state logic: a completion in ISS without acceptance aborts the issue
  // because it steals the PC port; last stays put so the same wave comes back.
  always_comb begin
    state_next = state;
    last_next  = last;
    cand_next  = cand;
    case (state)
      ST_SEL: begin
        if (sel_fire) begin
          state_next = ST_ISS;
          cand_next  = rr_idx;
        end
      end
      ST_ISS: begin
        if (issue_ready) begin
          state_next = ST_SEL;
          last_next  = cand;
        end else if (complete_valid) begin
          state_next = ST_SEL;
        end
      end
      default: state_next = ST_SEL;
    endcase
  end

  // Output decode: the PC block is addressed by whoever owns the port this cycle.
  always_comb begin
    dispatch_ready    = disp_ok;
    dispatch_slot     = free_idx;
    issue_valid       = (state == ST_ISS);
    issue_context     = cand;
    update_pc         = complete_valid & ~complete_exit;
    dispatch_new_wave = dispatch_fire;
    slot_free_mask    = '0;
    for (int i = 0; i < NUM_WAVES; i++) begin
      slot_free_mask[i] = (slot_status[i] == SLOT_FREE);
    end
    idle = (&slot_free_mask) & (state == ST_SEL);
    if (complete_valid) begin
      active_context = complete_context;
    end else if (dispatch_fire) begin
      active_context = free_idx;
    end else if (state == ST_ISS) begin
      active_context = cand;
    end else if (sel_fire) begin
      active_context = rr_idx;
    end else begin
      active_context = '0;
    end
  end

`ifndef SYNTHESIS
  // A completion must name a wave that has an instruction in flight.
  illegal_completion : assert property (@(posedge clk) disable iff (rst)
    complete_valid |-> complete_hits_busy);

  // The PC block cannot increment and zero a context in the same cycle.
  exclusive_strobes : assert property (@(posedge clk) disable iff (rst)
    !(update_pc && dispatch_new_wave));
`endif

endmodule

// File: tb/tb_wave_scheduler.sv
// tb_wave_scheduler: directed stimulus for wave_scheduler with a slot-list
// reference model checked every cycle plus hand-computed literal expectations.
module tb_wave_scheduler;

  localparam int NW  = 5;
  localparam int CWB = 3;

  logic           clk;
  logic           rst;
  logic           dispatch_valid;
  logic           dispatch_ready;
  logic [CWB-1:0] dispatch_slot;
  logic           issue_valid;
  logic           issue_ready;
  logic [CWB-1:0] issue_context;
  logic           complete_valid;
  logic [CWB-1:0] complete_context;
  logic           complete_exit;
  logic           update_pc;
  logic           dispatch_new_wave;
  logic [CWB-1:0] active_context;
  logic [NW-1:0]  slot_free_mask;
  logic           idle;

  int errors = 0;
  int checks = 0;

  // Reference model: 0 = free, 1 = ready, 2 = busy.
  int m_status [NW];
  bit m_in_iss;
  int m_last;
  int m_cand;
  int free_q[$];
  int e_cand, e_dslot, e_active, e_mask, probe;
  bit e_dready, e_dfire, e_sel, e_idle;
  bit was_iss;

  wave_scheduler #(.NUM_WAVES(NW)) dut (
    .clk               (clk),
    .rst               (rst),
    .dispatch_valid    (dispatch_valid),
    .dispatch_ready    (dispatch_ready),
    .dispatch_slot     (dispatch_slot),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_context     (issue_context),
    .complete_valid    (complete_valid),
    .complete_context  (complete_context),
    .complete_exit     (complete_exit),
    .update_pc         (update_pc),
    .dispatch_new_wave (dispatch_new_wave),
    .active_context    (active_context),
    .slot_free_mask    (slot_free_mask),
    .idle              (idle)
  );

  // Free-running clock, rising edge active.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after the edge, return at the mid-cycle sample point.
  task automatic applyStimulus(input bit dv, input bit ir, input bit cv, input int cc, input bit ce);
    @(posedge clk);
    #1;
    dispatch_valid   = dv;
    issue_ready      = ir;
    complete_valid   = cv;
    complete_context = CWB'(cc);
    complete_exit    = ce;
    @(negedge clk);
  endtask

  task automatic resetDut(input int cycles);
    @(posedge clk);
    #1;
    rst              = 1'b1;
    dispatch_valid   = 1'b0;
    issue_ready      = 1'b0;
    complete_valid   = 1'b0;
    complete_context = '0;
    complete_exit    = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Every mid-cycle: predict outputs from the model, compare, then advance the model.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) m_status[i] = 0;
      m_in_iss = 1'b0;
      m_last   = NW - 1;
      m_cand   = 0;
    end else begin
      free_q.delete();
      for (int i = 0; i < NW; i++) if (m_status[i] == 0) free_q.push_back(i);
      e_dready = (free_q.size() > 0) && !complete_valid && !m_in_iss;
      e_dslot  = (free_q.size() > 0) ? free_q[0] : 0;
      e_dfire  = dispatch_valid && e_dready;
      e_cand   = -1;
      for (int k = 1; k <= NW; k++) begin
        probe = (m_last + k) % NW;
        if (e_cand < 0 && m_status[probe] == 1) e_cand = probe;
      end
      e_sel = !m_in_iss && !complete_valid && !e_dfire && (e_cand >= 0);
      if (complete_valid)  e_active = int'(complete_context);
      else if (e_dfire)    e_active = e_dslot;
      else if (m_in_iss)   e_active = m_cand;
      else if (e_sel)      e_active = e_cand;
      else                 e_active = 0;
      e_mask = 0;
      for (int i = 0; i < NW; i++) if (m_status[i] == 0) e_mask |= (1 << i);
      e_idle = (free_q.size() == NW) && !m_in_iss;

      checkOutput("model.dispatch_ready", dispatch_ready, e_dready);
      checkOutput("model.dispatch_slot", dispatch_slot, e_dslot);
      checkOutput("model.issue_valid", issue_valid, m_in_iss);
      if (m_in_iss) checkOutput("model.issue_context", issue_context, m_cand);
      checkOutput("model.update_pc", update_pc, complete_valid && !complete_exit);
      checkOutput("model.dispatch_new_wave", dispatch_new_wave, e_dfire);
      checkOutput("model.active_context", active_context, e_active);
      checkOutput("model.slot_free_mask", slot_free_mask, e_mask);
      checkOutput("model.idle", idle, e_idle);

      if (complete_valid && m_status[complete_context] == 2)
        m_status[complete_context] = complete_exit ? 0 : 1;
      if (e_dfire) m_status[e_dslot] = 1;
      was_iss = m_in_iss;
      if (was_iss && issue_ready) begin
        m_status[m_cand] = 2;
        m_last = m_cand;
      end
      if (was_iss) m_in_iss = !(issue_ready || complete_valid);
      else begin
        m_in_iss = e_sel;
        if (e_sel) m_cand = e_cand;
      end
    end
  end

  // Directed scenario sequence with literal expectations.
  initial begin
    int seq [5];
    seq = '{0, 1, 2, 3, 0};
    rst              = 1'b1;
    dispatch_valid   = 1'b0;
    issue_ready      = 1'b0;
    complete_valid   = 1'b0;
    complete_context = '0;
    complete_exit    = 1'b0;

    resetDut(2);
    $display("[TB] reset values");
    checkOutput("rst.issue_valid", issue_valid, 0);
    checkOutput("rst.update_pc", update_pc, 0);
    checkOutput("rst.dispatch_new_wave", dispatch_new_wave, 0);
    checkOutput("rst.active_context", active_context, 0);
    checkOutput("rst.dispatch_ready", dispatch_ready, 1);
    checkOutput("rst.dispatch_slot", dispatch_slot, 0);
    checkOutput("rst.slot_free_mask", slot_free_mask, 5'b11111);
    checkOutput("rst.idle", idle, 1);

    $display("[TB] single dispatch to issue");
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("disp1.dispatch_new_wave", dispatch_new_wave, 1);
    checkOutput("disp1.active_context", active_context, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("disp1.sel_issue_valid", issue_valid, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("disp1.issue_valid", issue_valid, 1);
    checkOutput("disp1.issue_context", issue_context, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("exit0.update_pc", update_pc, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("exit0.idle", idle, 1);

    $display("[TB] fill all slots");
    for (int i = 0; i < NW; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("fill.dispatch_slot", dispatch_slot, i);
    end
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("full.dispatch_ready", dispatch_ready, 0);
    checkOutput("full.dispatch_new_wave", dispatch_new_wave, 0);
    checkOutput("full.slot_free_mask", slot_free_mask, 0);
    resetDut(1);

    $display("[TB] round-robin issue with wrap");
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("rr.sel_issue_valid", issue_valid, 0);
      if (k == 3) begin
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("rr.cmpl_update_pc", update_pc, 1);
        checkOutput("rr.cmpl_active", active_context, 0);
      end else begin
        applyStimulus(0, 1, 0, 0, 0);
      end
      checkOutput("rr.issue_valid", issue_valid, 1);
      checkOutput("rr.issue_context", issue_context, seq[k]);
    end
    foreach (seq[k]) begin
      if (k >= 1) begin
        applyStimulus(0, 0, 1, seq[k], 0);
        checkOutput("cmpl.update_pc", update_pc, 1);
        checkOutput("cmpl.active_context", active_context, seq[k]);
      end
    end

    $display("[TB] completion aborts pending issue");
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("abort.first_issue", issue_context, 1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("abort.iss_context", issue_context, 2);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("abort.update_pc", update_pc, 1);
    checkOutput("abort.active_context", active_context, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("abort.sel_issue_valid", issue_valid, 0);
    checkOutput("abort.sel_active", active_context, 2);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("abort.reissue_valid", issue_valid, 1);
    checkOutput("abort.reissue_context", issue_context, 2);
    applyStimulus(0, 1, 0, 0, 0);

    $display("[TB] exit frees slot for next dispatch");
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("exit3.issue_context", issue_context, 3);
    applyStimulus(0, 0, 1, 3, 1);
    checkOutput("exit3.update_pc", update_pc, 0);
    checkOutput("exit3.active_context", active_context, 3);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("exit3.slot_free_mask", slot_free_mask, 5'b11000);
    checkOutput("exit3.dispatch_slot", dispatch_slot, 3);
    checkOutput("exit3.dispatch_new_wave", dispatch_new_wave, 1);

    $display("[TB] reset during issue");
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("midrst.pre_issue_valid", issue_valid, 1);
    checkOutput("midrst.pre_issue_context", issue_context, 3);
    checkOutput("midrst.pre_mask", slot_free_mask, 5'b10000);
    resetDut(1);
    checkOutput("midrst.slot_free_mask", slot_free_mask, 5'b11111);
    checkOutput("midrst.issue_valid", issue_valid, 0);
    checkOutput("midrst.idle", idle, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
